// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

   localparam int          INSTR_W          = 32;
   localparam logic [31:0] PC_STEP          = 32'd4;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef struct packed {
      logic [31:0]        pc;
      logic [INSTR_W-1:0] instr;
   } fetch_entry_t;

   // Redirect targets are always word aligned.
   function automatic logic [31:0] align_pc(input logic [31:0] pc);
      return pc & ~32'h0000_0003;
   endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction RAM port, redirect input and decode handshake of the fetch unit.
interface instr_fetch_if;
   import fetch_pkg::*;

   logic [31:0]        imem_pc;
   logic [INSTR_W-1:0] imem_instr;
   logic               redirect_valid;
   logic [31:0]        redirect_pc;
   logic               out_valid;
   logic               out_ready;
   logic [INSTR_W-1:0] out_instr;
   logic [31:0]        out_pc;

   // Fetch unit side.
   modport master (
      output imem_pc,
      input  imem_instr,
      input  redirect_valid,
      input  redirect_pc,
      output out_valid,
      input  out_ready,
      output out_instr,
      output out_pc
   );

   // RAM / core side.
   modport slave (
      input  imem_pc,
      output imem_instr,
      output redirect_valid,
      output redirect_pc,
      input  out_valid,
      output out_ready,
      input  out_instr,
      input  out_pc
   );

endinterface

// File: rtl/fetch_fifo.sv
// Shift-style sync FIFO of fetched {pc, instr}; entry 0 is the head, so the
// head output comes straight from a register.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter  int DEPTH = 2,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic         pop,
   input  logic         flush,
   input  fetch_entry_t din,
   output fetch_entry_t head,
   output logic [CW-1:0] count
);

   fetch_entry_t  mem_q [DEPTH];
   fetch_entry_t  mem_d [DEPTH];
   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;
   logic [CW-1:0] wr_idx;
   logic          pop_ok;
   logic          push_ok;

   // Next-state: shift on pop, write behind the last live entry on push.
   always_comb begin
      mem_d   = mem_q;
      count_d = count_q;
      pop_ok  = pop && (count_q != '0);
      push_ok = push && ((count_q < CW'(DEPTH)) || pop_ok);
      wr_idx  = pop_ok ? (count_q - CW'(1)) : count_q;
      if (flush) begin
         count_d = '0;
      end else begin
         if (pop_ok) begin
            for (int i = 0; i < DEPTH - 1; i++) mem_d[i] = mem_q[i+1];
         end
         if (push_ok) begin
            for (int i = 0; i < DEPTH; i++) begin
               if (CW'(i) == wr_idx) mem_d[i] = din;
            end
         end
         count_d = count_q + CW'(push_ok) - CW'(pop_ok);
      end
   end

   // Storage and occupancy registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         count_q <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
         count_q <= count_d;
      end
   end

   assign head  = mem_q[0];
   assign count = count_q;

endmodule

// File: rtl/instr_fetch.sv
// Fetch front end: issues PCs to the instruction RAM under a credit check so
// every returned word has a buffer slot, and flushes on redirect.
module instr_fetch
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
   parameter int          DEPTH    = 2
) (
   input logic           clk,
   input logic           rst_n,
   instr_fetch_if.master bus
);

   localparam int CW = $clog2(DEPTH + 1);

   logic [31:0]   pc_q;
   logic          issued_v;
   logic [31:0]   issued_pc;
   logic [CW-1:0] count;
   logic [CW:0]   occ;
   logic          pop;
   logic          push;
   logic          issue;
   fetch_entry_t  head;
   fetch_entry_t  din;

   assign pop   = bus.out_valid && bus.out_ready;
   // Occupancy once the word now on the RAM bus lands and decode takes its pop.
   assign occ   = {1'b0, count} + (CW+1)'(issued_v) - (CW+1)'(pop);
   assign issue = (occ < (CW+1)'(DEPTH)) && !bus.redirect_valid;
   assign push  = issued_v && !bus.redirect_valid;
   assign din   = '{pc: issued_pc, instr: bus.imem_instr};

   // PC and in-flight tracking; a redirect overrides any issue.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q      <= RESET_PC;
         issued_v  <= 1'b0;
         issued_pc <= '0;
      end else if (bus.redirect_valid) begin
         pc_q     <= align_pc(bus.redirect_pc);
         issued_v <= 1'b0;
      end else if (issue) begin
         pc_q      <= pc_q + PC_STEP;
         issued_v  <= 1'b1;
         issued_pc <= pc_q;
      end else begin
         issued_v <= 1'b0;
      end
   end

   fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .flush (bus.redirect_valid),
      .din   (din),
      .head  (head),
      .count (count)
   );

   assign bus.imem_pc   = pc_q;
   assign bus.out_valid = (count != '0);
   assign bus.out_instr = head.instr;
   assign bus.out_pc    = head.pc;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: vector tables for streaming, stall and
// redirect, plus a wrapping-PC instance and an asynchronous mid-stream reset.
module tb_instr_fetch;
   import fetch_pkg::*;

   logic clk;
   logic rst_n;
   int   n_tests;
   int   n_fail;

   instr_fetch_if bus ();
   instr_fetch_if bus2 ();

   instr_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.master)
   );

   instr_fetch #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) dut2 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus2.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] prog(input logic [31:0] pc);
      case (pc)
         32'h0000_0000: return 32'h0485_0001;
         32'h0000_0004: return 32'h0486_0004;
         default:       return pc ^ 32'h1300_0013;
      endcase
   endfunction

   // Synchronous instruction RAM models: data one clock after the address.
   always @(posedge clk) bus.imem_instr  <= prog(bus.imem_pc);
   always @(posedge clk) bus2.imem_instr <= prog(bus2.imem_pc);

   typedef struct {
      logic        ready;
      logic        rv;
      logic [31:0] rpc;
      logic        ov;
      logic [31:0] opc;
      logic [31:0] ipc;
      logic        chk2;
      logic        ov2;
      logic [31:0] opc2;
   } vec_t;

   vec_t vec_a[$];
   vec_t vec_b[$];

   function automatic vec_t mk(input logic ready, input logic rv, input logic [31:0] rpc,
                               input logic ov, input logic [31:0] opc, input logic [31:0] ipc,
                               input logic chk2, input logic ov2, input logic [31:0] opc2);
      vec_t v;
      v.ready = ready; v.rv = rv; v.rpc = rpc; v.ov = ov; v.opc = opc; v.ipc = ipc;
      v.chk2 = chk2; v.ov2 = ov2; v.opc2 = opc2;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Called at a negedge: check the state of this cycle, then drive its inputs.
   task automatic run_vectors(input string tag, input vec_t vq[$]);
      for (int k = 0; k < vq.size(); k++) begin
         chk($sformatf("%s[%0d] out_valid", tag, k), 32'(bus.out_valid), 32'(vq[k].ov));
         chk($sformatf("%s[%0d] imem_pc", tag, k), bus.imem_pc, vq[k].ipc);
         if (vq[k].ov) begin
            chk($sformatf("%s[%0d] out_pc", tag, k), bus.out_pc, vq[k].opc);
            chk($sformatf("%s[%0d] out_instr", tag, k), bus.out_instr, prog(vq[k].opc));
         end
         if (vq[k].chk2) begin
            chk($sformatf("%s[%0d] wrap out_valid", tag, k), 32'(bus2.out_valid), 32'(vq[k].ov2));
            if (vq[k].ov2) begin
               chk($sformatf("%s[%0d] wrap out_pc", tag, k), bus2.out_pc, vq[k].opc2);
               chk($sformatf("%s[%0d] wrap out_instr", tag, k), bus2.out_instr, prog(vq[k].opc2));
            end
         end
         bus.out_ready      = vq[k].ready;
         bus.redirect_valid = vq[k].rv;
         bus.redirect_pc    = vq[k].rpc;
         @(negedge clk);
      end
      bus.redirect_valid = 1'b0;
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, " out_valid"}, 32'(bus.out_valid), 32'd0);
      chk({tag, " out_pc"}, bus.out_pc, 32'd0);
      chk({tag, " out_instr"}, bus.out_instr, 32'd0);
      chk({tag, " imem_pc"}, bus.imem_pc, 32'd0);
      chk({tag, " wrap imem_pc"}, bus2.imem_pc, 32'hFFFF_FFF8);
      chk({tag, " wrap out_valid"}, 32'(bus2.out_valid), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst_n               = 1'b0;
      bus.out_ready       = 1'b0;
      bus.redirect_valid  = 1'b0;
      bus.redirect_pc     = '0;
      bus2.out_ready      = 1'b1;
      bus2.redirect_valid = 1'b0;
      bus2.redirect_pc    = '0;

      // Streaming with ready high; redirect to 0x17 with a pop in the same cycle.
      //                ready rv rpc     ov opc    imem    chk2 ov2 opc2
      vec_a.push_back(mk(1, 0, 32'h0,  0, 32'h0,  32'h00, 1, 0, 32'h0));
      vec_a.push_back(mk(1, 0, 32'h0,  0, 32'h0,  32'h04, 1, 0, 32'h0));
      vec_a.push_back(mk(1, 0, 32'h0,  1, 32'h0,  32'h08, 1, 1, 32'hFFFF_FFF8));
      vec_a.push_back(mk(1, 0, 32'h0,  1, 32'h4,  32'h0C, 1, 1, 32'hFFFF_FFFC));
      vec_a.push_back(mk(1, 0, 32'h0,  1, 32'h8,  32'h10, 1, 1, 32'h0000_0000));
      vec_a.push_back(mk(1, 0, 32'h0,  1, 32'hC,  32'h14, 1, 1, 32'h4));
      vec_a.push_back(mk(1, 1, 32'h17, 1, 32'h10, 32'h18, 1, 1, 32'h8));
      vec_a.push_back(mk(1, 0, 32'h0,  0, 32'h0,  32'h14, 1, 1, 32'hC));
      vec_a.push_back(mk(1, 0, 32'h0,  0, 32'h0,  32'h18, 1, 1, 32'h10));
      vec_a.push_back(mk(1, 0, 32'h0,  1, 32'h14, 32'h1C, 1, 1, 32'h14));
      vec_a.push_back(mk(1, 0, 32'h0,  1, 32'h18, 32'h20, 1, 1, 32'h18));

      // Stall after the first word, resume, refill to 2 entries, redirect to 0x14.
      vec_b.push_back(mk(0, 0, 32'h0,  0, 32'h0,  32'h00, 0, 0, 32'h0));
      vec_b.push_back(mk(0, 0, 32'h0,  0, 32'h0,  32'h04, 0, 0, 32'h0));
      vec_b.push_back(mk(0, 0, 32'h0,  1, 32'h0,  32'h08, 0, 0, 32'h0));
      vec_b.push_back(mk(0, 0, 32'h0,  1, 32'h0,  32'h08, 0, 0, 32'h0));
      vec_b.push_back(mk(0, 0, 32'h0,  1, 32'h0,  32'h08, 0, 0, 32'h0));
      vec_b.push_back(mk(0, 0, 32'h0,  1, 32'h0,  32'h08, 0, 0, 32'h0));
      vec_b.push_back(mk(0, 0, 32'h0,  1, 32'h0,  32'h08, 0, 0, 32'h0));
      vec_b.push_back(mk(1, 0, 32'h0,  1, 32'h0,  32'h08, 0, 0, 32'h0));
      vec_b.push_back(mk(1, 0, 32'h0,  1, 32'h4,  32'h0C, 0, 0, 32'h0));
      vec_b.push_back(mk(1, 0, 32'h0,  1, 32'h8,  32'h10, 0, 0, 32'h0));
      vec_b.push_back(mk(0, 0, 32'h0,  1, 32'hC,  32'h14, 0, 0, 32'h0));
      vec_b.push_back(mk(0, 1, 32'h14, 1, 32'hC,  32'h14, 0, 0, 32'h0));
      vec_b.push_back(mk(0, 0, 32'h0,  0, 32'h0,  32'h14, 0, 0, 32'h0));
      vec_b.push_back(mk(0, 0, 32'h0,  0, 32'h0,  32'h18, 0, 0, 32'h0));
      vec_b.push_back(mk(1, 0, 32'h0,  1, 32'h14, 32'h1C, 0, 0, 32'h0));
      vec_b.push_back(mk(1, 0, 32'h0,  1, 32'h18, 32'h20, 0, 0, 32'h0));

      repeat (3) @(negedge clk);
      check_reset_values("reset");
      rst_n = 1'b1;
      run_vectors("stream", vec_a);

      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      run_vectors("stall", vec_b);

      // Asynchronous reset in the middle of a cycle while streaming.
      bus.out_ready = 1'b1;
      repeat (2) @(negedge clk);
      chk("pre-reset out_valid", 32'(bus.out_valid), 32'd1);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 check_reset_values("midreset");
      @(negedge clk);
      rst_n = 1'b1;
      run_vectors("restart", vec_a);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch front end for the single-cycle core. It drives the program counter into the instruction RAM and captures the returned words, which arrive one clock after the address is sampled. It presents each word with its PC to decode through a valid/ready handshake. It absorbs decode back-pressure and handles jump/branch redirects by flushing everything in flight.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000: PC fetched first after reset.
- DEPTH, 2: output buffer entries; minimum 2, which is required for one instruction per cycle.

Ports:
- clk  in  1: single clock; all state updates on posedge.
- rst_n  in  1: asynchronous, active-low reset.
- imem_pc  out  32: address to instruction RAM; registered (pc_q).
- imem_instr  in  32: RAM read data; valid the cycle after the RAM samples imem_pc at posedge.
- redirect_valid  in  1: taken jump/branch this cycle.
- redirect_pc  in  32: redirect target; bits [1:0] ignored (forced to 0).
- out_valid  out  1: out_instr/out_pc hold a fetched instruction.
- out_ready  in  1: decode accepts when out_valid & out_ready.
- out_instr  out  32: instruction word (buffer head).
- out_pc  out  32: PC of out_instr.

## Operation
- State:
  - pc_q: next address, drives imem_pc.
  - issued_v/issued_pc: the RAM word on the bus this cycle belongs to issued_pc.
  - DEPTH-entry FIFO of {pc, instr}, with count.
- pop = out_valid & out_ready.
- occ = count + issued_v - pop.
- Issue at a posedge when occ < DEPTH and no redirect:
  - pc_q <= pc_q + 4, wrapping 32'hFFFF_FFFC -> 0.
  - issued_v <= 1, issued_pc <= pc_q.
- No issue: pc_q holds, issued_v <= 0. The RAM re-reads the same address, and the result is not captured.
- Capture: when issued_v = 1 and no redirect, push {issued_pc, imem_instr} into the FIFO. The credit check makes the FIFO never overflow.
- Pop and push in the same cycle are both allowed; when empty, a pushed word appears on out_* the next cycle (no bypass).
- Redirect has priority over everything:
  - pc_q <= {redirect_pc[31:2], 2'b00}.
  - issued_v <= 0, FIFO flushed (count <= 0).
  - A pop in that same cycle still counts as consumed by decode.
  - Back-to-back redirects: the last one wins.
- Reset, asynchronous and valid at any point including mid-stream:
  - pc_q = RESET_PC, issued_v = 0, count = 0.
  - out_valid = 0, out_instr = 0, out_pc = 0.
  - imem_pc = RESET_PC.
- out_instr/out_pc are stable while out_valid = 1 and out_ready = 0.

## Timing
- Reset release: imem_pc = RESET_PC during the first cycle.
  - Edge 1: RAM samples the address, issued_v = 1.
  - Edge 2: push.
  - out_valid high after edge 2.
- Redirect sampled at edge r: imem_pc = target after r, out_valid with out_pc = target after edge r+2. Two bubble cycles.
- Throughput: one instruction per cycle with out_ready held high.
- Stall: with out_ready = 0, the FIFO fills to DEPTH within 2 cycles and pc_q then freezes. Resuming gives one instruction per cycle after one cycle.
- No combinational path from any input to any output.

## Structure
- Package fetch_pkg:
  - INSTR_W = 32, PC_STEP = 4.
  - Default RESET_PC.
  - Type fetch_entry_t {pc, instr}.
- Sub-module fetch_fifo:
  - Parameterised sync FIFO (DEPTH, fetch_entry_t) with push, pop, flush and count.
  - Registered head output.
  - Same clk/rst_n.

## Test plan
- Reset then out_ready = 1, RAM loaded with the core test program:
  - out_pc 0, 4, 8, ... on consecutive cycles.
  - out_instr 32'h0485_0001, then 32'h0486_0004.
- out_ready = 0 for 5 cycles after the first word:
  - out_pc stays 0.
  - imem_pc freezes at 8.
  - On release, words 0, 4, 8, 12 follow with none lost or duplicated.
- redirect_valid with redirect_pc = 32'h14 while the FIFO holds 2 entries:
  - Entries are dropped.
  - Next out_pc = 32'h14, 2 cycles later.
- Redirect and pop in the same cycle, plus redirect_pc = 32'h17: fetch resumes at 32'h14.
- RESET_PC = 32'hFFFF_FFF8: out_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Assert rst_n low mid-stream: out_valid drops immediately, and after release fetch restarts at RESET_PC.
